// File: rtl/trail_manager.sv
// Trail particle manager: keeps a ring of fading trail particles behind the
// player. Once per frame it sweeps every slot to age and drift the particles,
// and every SPAWN_PERIOD running frames it drops a fresh particle at the player.
module trail_manager #(
   parameter int DEPTH        = 41,
   parameter int LIFE_MAX     = 10,
   parameter int SPAWN_X      = 158,
   parameter int PLAYER_SIZE  = 40,
   parameter int SPAWN_PERIOD = 2,
   parameter int DRIFT        = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   frame_tick,
   input  logic [1:0]             gamemode,
   input  logic [8:0]             player_y,
   output logic [DEPTH-1:0][9:0]  trail_x,
   output logic [DEPTH-1:0][8:0]  trail_y,
   output logic [DEPTH-1:0][3:0]  trail_life,
   output logic [5:0]             active_count,
   output logic                   busy,
   output logic                   overrun
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int SC_W  = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
   localparam logic [SC_W-1:0]  LAST_SC  = SC_W'(SPAWN_PERIOD - 1);
   localparam logic [9:0]       DRIFT_X  = 10'(DRIFT);
   localparam logic [9:0]       SPAWN_XV = 10'(SPAWN_X);
   localparam logic [3:0]       LIFE_V   = 4'(LIFE_MAX);
   localparam logic [8:0]       Y_OFS    = 9'(PLAYER_SIZE / 2);
   localparam logic [5:0]       CNT_MAX  = 6'(DEPTH);

   typedef enum logic [1:0] {IDLE, DECAY, SPAWN, CLEAR} state_t;

   state_t           state, state_nx;
   logic [IDX_W-1:0] idx, idx_nx, wr_ptr;
   logic [SC_W-1:0]  spawn_cnt;
   logic [1:0]       prev_mode;
   logic             clear_trig, sweep_end, spawn_go, kill, birth;
   logic [9:0]       cur_x;
   logic [3:0]       cur_life, wr_life;

   // Population counter step, clamped to the legal 0..DEPTH range.
   function automatic logic [5:0] count_step(input logic [5:0] cnt, input logic inc, input logic dec);
      if (inc && !dec && (cnt < CNT_MAX)) return cnt + 6'd1;
      if (dec && !inc && (cnt != 6'd0))   return cnt - 6'd1;
      return cnt;
   endfunction

   // Entering start mode wipes the trail and wins over anything in flight.
   assign clear_trig = (prev_mode != 2'b00) && (gamemode == 2'b00);
   assign cur_x      = trail_x[idx];
   assign cur_life   = trail_life[idx];
   assign wr_life    = trail_life[wr_ptr];
   assign sweep_end  = (idx == LAST_IDX);
   assign spawn_go   = (gamemode == 2'b01) && (spawn_cnt == LAST_SC);
   assign kill       = (state == DECAY) && !clear_trig && (cur_life != 4'd0) &&
                       ((cur_life == 4'd1) || (cur_x < DRIFT_X));
   assign birth      = (state == SPAWN) && !clear_trig && (wr_life == 4'd0);
   assign busy       = (state != IDLE);

   // Next-state and slot index sequencing.
   always_comb begin
      state_nx = state;
      idx_nx   = idx;
      case (state)
         IDLE: begin
            if (frame_tick && gamemode[0]) begin
               state_nx = DECAY;
               idx_nx   = '0;
            end
         end
         DECAY: begin
            if (sweep_end) begin
               state_nx = spawn_go ? SPAWN : IDLE;
               idx_nx   = '0;
            end else begin
               idx_nx = idx + IDX_W'(1);
            end
         end
         SPAWN: state_nx = IDLE;
         CLEAR: begin
            if (sweep_end) begin
               state_nx = IDLE;
               idx_nx   = '0;
            end else begin
               idx_nx = idx + IDX_W'(1);
            end
         end
         default: state_nx = IDLE;
      endcase
      if (clear_trig) begin
         state_nx = CLEAR;
         idx_nx   = '0;
      end
   end

   // FSM state, sweep index and previous-mode register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         idx       <= '0;
         prev_mode <= 2'b00;
      end else begin
         state     <= state_nx;
         idx       <= idx_nx;
         prev_mode <= gamemode;
      end
   end

   // Write pointer, spawn cadence, population count and overrun flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr       <= '0;
         spawn_cnt    <= '0;
         active_count <= 6'd0;
         overrun      <= 1'b0;
      end else if (clear_trig) begin
         wr_ptr       <= '0;
         spawn_cnt    <= '0;
         active_count <= 6'd0;
         overrun      <= 1'b0;
      end else begin
         if (frame_tick && busy)
            overrun <= 1'b1;
         if ((state == DECAY) && sweep_end && (gamemode == 2'b01))
            spawn_cnt <= (spawn_cnt == LAST_SC) ? '0 : spawn_cnt + SC_W'(1);
         if (state == SPAWN)
            wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + IDX_W'(1);
         active_count <= count_step(active_count, birth, kill);
      end
   end

   // Slot storage: age/drift during sweeps, fresh particle on spawn, wipe on clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trail_x    <= '0;
         trail_y    <= '0;
         trail_life <= '0;
      end else if (!clear_trig) begin
         case (state)
            DECAY: begin
               if (cur_life != 4'd0) begin
                  if (cur_x >= DRIFT_X) begin
                     trail_life[idx] <= cur_life - 4'd1;
                     trail_x[idx]    <= cur_x - DRIFT_X;
                  end else begin
                     trail_life[idx] <= 4'd0;
                     trail_x[idx]    <= 10'd0;
                  end
               end
            end
            SPAWN: begin
               trail_x[wr_ptr]    <= SPAWN_XV;
               trail_y[wr_ptr]    <= player_y + Y_OFS;
               trail_life[wr_ptr] <= LIFE_V;
            end
            CLEAR: begin
               trail_x[idx]    <= 10'd0;
               trail_y[idx]    <= 9'd0;
               trail_life[idx] <= 4'd0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_trail_manager.sv
// Directed bench for trail_manager: three instances share stimulus -- the
// default build, one spawning near the left edge (x underflow path) and one
// with only three slots (live-slot overwrite path).
module tb_trail_manager;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        frame_tick = 1'b0;
   logic [1:0]  gamemode = 2'b00;
   logic [8:0]  player_y = 9'd0;

   logic [40:0][9:0] a_x;
   logic [40:0][8:0] a_y;
   logic [40:0][3:0] a_life;
   logic [5:0]       a_cnt;
   logic             a_busy, a_ovr;

   logic [40:0][9:0] b_x;
   logic [40:0][8:0] b_y;
   logic [40:0][3:0] b_life;
   logic [5:0]       b_cnt;
   logic             b_busy, b_ovr;

   logic [2:0][9:0]  c_x;
   logic [2:0][8:0]  c_y;
   logic [2:0][3:0]  c_life;
   logic [5:0]       c_cnt;
   logic             c_busy, c_ovr;

   int n_cmp = 0;
   int n_err = 0;

   trail_manager dut_a (
      .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .gamemode(gamemode), .player_y(player_y),
      .trail_x(a_x), .trail_y(a_y), .trail_life(a_life), .active_count(a_cnt), .busy(a_busy), .overrun(a_ovr));

   trail_manager #(.SPAWN_X(11)) dut_b (
      .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .gamemode(gamemode), .player_y(player_y),
      .trail_x(b_x), .trail_y(b_y), .trail_life(b_life), .active_count(b_cnt), .busy(b_busy), .overrun(b_ovr));

   trail_manager #(.DEPTH(3)) dut_c (
      .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .gamemode(gamemode), .player_y(player_y),
      .trail_x(c_x), .trail_y(c_y), .trail_life(c_life), .active_count(c_cnt), .busy(c_busy), .overrun(c_ovr));

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Pulse frame_tick for one cycle; returns at the negedge of cycle T+1.
   task automatic do_tick();
      @(negedge clk);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
   endtask

   task automatic tick_sweep();
      do_tick();
      wait_cyc(44);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      wait_cyc(3);
      n_cmp++; if (a_cnt !== 6'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", a_cnt); end
      n_cmp++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", a_busy); end
      n_cmp++; if (a_ovr !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b want 0", a_ovr); end
      n_cmp++; if (a_life !== '0 || a_x !== '0 || a_y !== '0) begin n_err++; $display("FAIL reset_slots: got nonzero slot data want all 0"); end
      @(negedge clk);
      rst_n = 1'b1;
      wait_cyc(2);
   endtask

   task automatic test_spawn();
      gamemode = 2'b01;
      player_y = 9'd200;
      wait_cyc(3);
      do_tick();
      n_cmp++; if (a_busy !== 1'b1) begin n_err++; $display("FAIL busy_t1: got %b want 1", a_busy); end
      wait_cyc(40);
      n_cmp++; if (a_busy !== 1'b1) begin n_err++; $display("FAIL busy_t41: got %b want 1", a_busy); end
      wait_cyc(1);
      n_cmp++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL busy_t42_nospawn: got %b want 0", a_busy); end
      n_cmp++; if (a_cnt !== 6'd0) begin n_err++; $display("FAIL first_sweep_count: got %0d want 0", a_cnt); end
      wait_cyc(6);
      do_tick();
      wait_cyc(41);
      n_cmp++; if (a_busy !== 1'b1 || a_life[0] !== 4'd0) begin n_err++; $display("FAIL spawn_cycle_t42: got busy %b life %0d want busy 1 life 0", a_busy, a_life[0]); end
      wait_cyc(1);
      n_cmp++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL busy_t43: got %b want 0", a_busy); end
      n_cmp++; if (a_x[0] !== 10'd158 || a_y[0] !== 9'd220 || a_life[0] !== 4'd10) begin n_err++; $display("FAIL spawn_slot0: got x %0d y %0d life %0d want 158 220 10", a_x[0], a_y[0], a_life[0]); end
      n_cmp++; if (a_cnt !== 6'd1) begin n_err++; $display("FAIL spawn_count: got %0d want 1", a_cnt); end
      n_cmp++; if (b_x[0] !== 10'd11 || b_cnt !== 6'd1) begin n_err++; $display("FAIL spawn_b: got x %0d cnt %0d want 11 1", b_x[0], b_cnt); end
      wait_cyc(2);
   endtask

   task automatic test_overrun();
      n_cmp++; if (a_ovr !== 1'b0) begin n_err++; $display("FAIL overrun_pre: got %b want 0", a_ovr); end
      do_tick();
      wait_cyc(8);
      do_tick();
      n_cmp++; if (a_ovr !== 1'b1) begin n_err++; $display("FAIL overrun_set: got %b want 1", a_ovr); end
      wait_cyc(40);
      n_cmp++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL overrun_idle: got busy %b want 0", a_busy); end
      n_cmp++; if (a_x[0] !== 10'd154 || a_life[0] !== 4'd9 || a_cnt !== 6'd1) begin n_err++; $display("FAIL overrun_single_decay: got x %0d life %0d cnt %0d want 154 9 1", a_x[0], a_life[0], a_cnt); end
      n_cmp++; if (b_x[0] !== 10'd7 || b_life[0] !== 4'd9) begin n_err++; $display("FAIL overrun_b: got x %0d life %0d want 7 9", b_x[0], b_life[0]); end
   endtask

   task automatic test_decay_edge();
      player_y = 9'd100;
      tick_sweep();
      n_cmp++; if (a_x[1] !== 10'd158 || a_y[1] !== 9'd120 || a_life[1] !== 4'd10 || a_cnt !== 6'd2) begin n_err++; $display("FAIL second_spawn: got x %0d y %0d life %0d cnt %0d want 158 120 10 2", a_x[1], a_y[1], a_life[1], a_cnt); end
      n_cmp++; if (b_x[0] !== 10'd3 || b_life[0] !== 4'd8 || b_cnt !== 6'd2) begin n_err++; $display("FAIL b_pre_edge: got x %0d life %0d cnt %0d want 3 8 2", b_x[0], b_life[0], b_cnt); end
      do_tick();
      wait_cyc(1);
      n_cmp++; if (b_x[0] !== 10'd0 || b_life[0] !== 4'd0 || b_y[0] !== 9'd220) begin n_err++; $display("FAIL b_underflow_kill: got x %0d y %0d life %0d want 0 220 0", b_x[0], b_y[0], b_life[0]); end
      n_cmp++; if (b_cnt !== 6'd1) begin n_err++; $display("FAIL b_kill_count: got %0d want 1", b_cnt); end
      wait_cyc(43);
      n_cmp++; if (a_x[0] !== 10'd146 || a_life[0] !== 4'd7 || a_life[1] !== 4'd9 || a_cnt !== 6'd2) begin n_err++; $display("FAIL decay_after_edge: got x %0d life %0d/%0d cnt %0d want 146 7/9 2", a_x[0], a_life[0], a_life[1], a_cnt); end
   endtask

   task automatic test_pause();
      gamemode = 2'b10;
      repeat (3) begin
         do_tick();
         n_cmp++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL pause_tick_ignored: got busy %b want 0", a_busy); end
         wait_cyc(5);
      end
      n_cmp++; if (a_x[0] !== 10'd146 || a_life[0] !== 4'd7 || a_life[1] !== 4'd9 || a_cnt !== 6'd2) begin n_err++; $display("FAIL pause_frozen: got x %0d life %0d/%0d cnt %0d want 146 7/9 2", a_x[0], a_life[0], a_life[1], a_cnt); end
      gamemode = 2'b01;
      wait_cyc(2);
      do_tick();
      wait_cyc(4);
      gamemode = 2'b10;
      wait_cyc(36);
      n_cmp++; if (a_busy !== 1'b1) begin n_err++; $display("FAIL pause_mid_sweep_continues: got busy %b want 1", a_busy); end
      wait_cyc(1);
      n_cmp++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL pause_mid_no_spawn: got busy %b want 0", a_busy); end
      wait_cyc(3);
      n_cmp++; if (a_x[0] !== 10'd142 || a_life[0] !== 4'd6 || a_x[1] !== 10'd150 || a_life[1] !== 4'd8 || a_life[2] !== 4'd0) begin n_err++; $display("FAIL pause_mid_decay: got x %0d life %0d x1 %0d life1 %0d life2 %0d want 142 6 150 8 0", a_x[0], a_life[0], a_x[1], a_life[1], a_life[2]); end
      gamemode = 2'b01;
      wait_cyc(2);
      tick_sweep();
      n_cmp++; if (a_x[2] !== 10'd158 || a_life[2] !== 4'd10 || a_life[0] !== 4'd5 || a_cnt !== 6'd3) begin n_err++; $display("FAIL resume_spawn: got x2 %0d life2 %0d life0 %0d cnt %0d want 158 10 5 3", a_x[2], a_life[2], a_life[0], a_cnt); end
   endtask

   task automatic test_gameover();
      gamemode = 2'b11;
      wait_cyc(2);
      tick_sweep();
      n_cmp++; if (a_life[0] !== 4'd4 || a_life[1] !== 4'd6 || a_life[2] !== 4'd9 || a_life[3] !== 4'd0 || a_cnt !== 6'd3) begin n_err++; $display("FAIL gameover_first: got %0d %0d %0d %0d cnt %0d want 4 6 9 0 3", a_life[0], a_life[1], a_life[2], a_life[3], a_cnt); end
      repeat (4) tick_sweep();
      n_cmp++; if (a_life[0] !== 4'd0 || a_cnt !== 6'd2) begin n_err++; $display("FAIL gameover_fade5: got life0 %0d cnt %0d want 0 2", a_life[0], a_cnt); end
      repeat (5) tick_sweep();
      n_cmp++; if (a_cnt !== 6'd0 || a_life !== '0) begin n_err++; $display("FAIL gameover_empty: got cnt %0d want 0 and all lives 0", a_cnt); end
   endtask

   task automatic test_wrap();
      int max_cnt;
      int c_sum;
      gamemode = 2'b00;
      wait_cyc(50);
      n_cmp++; if (a_busy !== 1'b0 || a_x[0] !== 10'd0 || a_y[1] !== 9'd0) begin n_err++; $display("FAIL idle_clear: got busy %b x0 %0d y1 %0d want 0 0 0", a_busy, a_x[0], a_y[1]); end
      gamemode = 2'b01;
      wait_cyc(2);
      max_cnt = 0;
      for (int t = 0; t < 90; t++) begin
         tick_sweep();
         if (int'(a_cnt) > max_cnt) max_cnt = int'(a_cnt);
      end
      n_cmp++; if (max_cnt !== 5) begin n_err++; $display("FAIL wrap_max_count: got %0d want 5", max_cnt); end
      n_cmp++; if (a_cnt !== 6'd5) begin n_err++; $display("FAIL wrap_count: got %0d want 5", a_cnt); end
      n_cmp++; if (a_x[3] !== 10'd158 || a_y[3] !== 9'd120 || a_life[3] !== 4'd10) begin n_err++; $display("FAIL wrap_last_spawn: got x %0d y %0d life %0d want 158 120 10", a_x[3], a_y[3], a_life[3]); end
      n_cmp++; if (a_x[0] !== 10'd134 || a_life[0] !== 4'd4) begin n_err++; $display("FAIL wrap_slot0_reuse: got x %0d life %0d want 134 4", a_x[0], a_life[0]); end
      n_cmp++; if (a_x[40] !== 10'd126 || a_life[40] !== 4'd2 || a_life[39] !== 4'd0 || a_life[4] !== 4'd0) begin n_err++; $display("FAIL wrap_tail: got x40 %0d life40 %0d life39 %0d life4 %0d want 126 2 0 0", a_x[40], a_life[40], a_life[39], a_life[4]); end
      c_sum = int'(c_life[0]) + int'(c_life[1]) + int'(c_life[2]);
      n_cmp++; if (c_cnt !== 6'd3 || c_sum !== 24) begin n_err++; $display("FAIL overwrite_live: got cnt %0d life_sum %0d want 3 24", c_cnt, c_sum); end
   endtask

   task automatic test_clear_mid();
      int nz;
      do_tick();
      wait_cyc(4);
      do_tick();
      n_cmp++; if (a_ovr !== 1'b1) begin n_err++; $display("FAIL clear_pre_overrun: got %b want 1", a_ovr); end
      wait_cyc(14);
      gamemode = 2'b00;
      frame_tick = 1'b1;
      wait_cyc(1);
      frame_tick = 1'b0;
      n_cmp++; if (a_busy !== 1'b1 || a_cnt !== 6'd0 || a_ovr !== 1'b0) begin n_err++; $display("FAIL clear_entry: got busy %b cnt %0d ovr %b want 1 0 0", a_busy, a_cnt, a_ovr); end
      wait_cyc(40);
      n_cmp++; if (a_busy !== 1'b1) begin n_err++; $display("FAIL clear_last_cycle: got busy %b want 1", a_busy); end
      wait_cyc(1);
      nz = 0;
      for (int i = 0; i < 41; i++)
         if (a_x[i] != 10'd0 || a_y[i] != 9'd0 || a_life[i] != 4'd0) nz++;
      n_cmp++; if (nz !== 0) begin n_err++; $display("FAIL clear_slots: got %0d nonzero slots want 0", nz); end
      n_cmp++; if (a_busy !== 1'b0 || a_cnt !== 6'd0 || a_ovr !== 1'b0) begin n_err++; $display("FAIL clear_done: got busy %b cnt %0d ovr %b want 0 0 0", a_busy, a_cnt, a_ovr); end
   endtask

   task automatic test_reset_async();
      gamemode = 2'b01;
      wait_cyc(2);
      tick_sweep();
      tick_sweep();
      n_cmp++; if (a_cnt !== 6'd1 || a_life[0] !== 4'd10) begin n_err++; $display("FAIL rst_pre_state: got cnt %0d life0 %0d want 1 10", a_cnt, a_life[0]); end
      do_tick();
      wait_cyc(2);
      do_tick();
      wait_cyc(3);
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++; if (a_cnt !== 6'd0 || a_busy !== 1'b0 || a_ovr !== 1'b0) begin n_err++; $display("FAIL async_reset_ctrl: got cnt %0d busy %b ovr %b want 0 0 0", a_cnt, a_busy, a_ovr); end
      n_cmp++; if (a_life[0] !== 4'd0 || a_x[0] !== 10'd0 || a_y[0] !== 9'd0) begin n_err++; $display("FAIL async_reset_slot: got x %0d y %0d life %0d want 0 0 0", a_x[0], a_y[0], a_life[0]); end
      @(negedge clk);
      rst_n = 1'b1;
      wait_cyc(3);
      n_cmp++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL reset_resume_idle: got busy %b want 0", a_busy); end
      tick_sweep();
      n_cmp++; if (a_cnt !== 6'd0 || a_busy !== 1'b0) begin n_err++; $display("FAIL reset_spawn_cnt: got cnt %0d busy %b want 0 0", a_cnt, a_busy); end
      tick_sweep();
      n_cmp++; if (a_life[0] !== 4'd10 || a_life[1] !== 4'd0 || a_cnt !== 6'd1) begin n_err++; $display("FAIL reset_wr_ptr: got life0 %0d life1 %0d cnt %0d want 10 0 1", a_life[0], a_life[1], a_cnt); end
   endtask

   initial begin
      test_reset();
      test_spawn();
      test_overrun();
      test_decay_edge();
      test_pause();
      test_gameover();
      test_wrap();
      test_clear_mid();
      test_reset_async();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
